// File: rtl/axis_fifo_counted.sv
// Single-clock AXI-Stream FIFO with a first-word-fall-through registered output,
// occupancy count and registered almost-full / almost-empty flags.
module axis_fifo_counted #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tvalid,
    input  logic [WIDTH-1:0]             s_axis_tdata,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [WIDTH-1:0]             m_axis_tdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned MEM_D = DEPTH - 1;
    localparam int unsigned PW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_C = PW'(MEM_D - 1);

    logic [WIDTH-1:0] mem [MEM_D];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic [CW-1:0]    count_next;
    logic             in_fire;
    logic             out_fire;
    logic             mem_empty;
    logic             oreg_load;
    logic             mem_push;
    logic             mem_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Transfer decode; an empty memory with a free output slot sends the word straight to the output.
    always_comb begin
        in_fire    = s_axis_tvalid && s_axis_tready && !rst;
        out_fire   = m_axis_tvalid && m_axis_tready;
        mem_empty  = (mem_count == '0);
        oreg_load  = !m_axis_tvalid || out_fire;
        mem_pop    = oreg_load && !mem_empty;
        mem_push   = in_fire && !(oreg_load && mem_empty);
        count_next = count + CW'(in_fire) - CW'(out_fire);
    end

    // Control state; ready and flags are computed from next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            mem_count     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
        end else begin
            count         <= count_next;
            mem_count     <= mem_count + CW'(mem_push) - CW'(mem_pop);
            s_axis_tready <= (count_next != FULL_C);
            almost_full   <= (count_next >= AF_C);
            almost_empty  <= (count_next <= AE_C);
            if (oreg_load) begin
                m_axis_tvalid <= !mem_empty || in_fire;
            end
            if (mem_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    // Data path carries no reset; contents are meaningless while the valid state is clear.
    always_ff @(posedge clk) begin
        if (!rst && oreg_load) begin
            if (!mem_empty) begin
                m_axis_tdata <= mem[rd_ptr];
            end else if (in_fire) begin
                m_axis_tdata <= s_axis_tdata;
            end
        end
        if (mem_push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (WIDTH < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH > DEPTH - 1) begin
            $error("axis_fifo_counted: parameter out of range");
            $finish;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= FULL_C)
                else $error("axis_fifo_counted: count exceeds depth");
            assert (m_axis_tvalid == (count != '0))
                else $error("axis_fifo_counted: tvalid inconsistent with count");
        end
    end
`endif

endmodule

// File: tb/tb_axis_fifo_counted.sv
// Directed and random bench for axis_fifo_counted; a DEPTH=4 and a DEPTH=5 instance are
// checked every cycle against an independent occupancy model and data scoreboard.
module tb_axis_fifo_counted;

    logic       clk = 1'b0;
    logic       rst;

    logic       s4_rdy, s4_vld, m4_rdy, m4_vld, af4, ae4;
    logic [7:0] s4_dat, m4_dat;
    logic [2:0] c4;
    logic       s5_rdy, s5_vld, m5_rdy, m5_vld, af5, ae5;
    logic [7:0] s5_dat, m5_dat;
    logic [2:0] c5;

    int errors = 0;
    int checks = 0;

    logic [7:0] q4[$];
    logic [7:0] q5[$];
    int         mc4 = 0;
    int         mc5 = 0;
    int         sent5 = 0;
    int         rcv5 = 0;
    int         max_c5 = 0;
    logic       acc5 = 1'b0;

    always #5 clk = ~clk;

    axis_fifo_counted #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) u_d4 (
        .clk(clk), .rst(rst),
        .s_axis_tready(s4_rdy), .s_axis_tvalid(s4_vld), .s_axis_tdata(s4_dat),
        .m_axis_tready(m4_rdy), .m_axis_tvalid(m4_vld), .m_axis_tdata(m4_dat),
        .count(c4), .almost_full(af4), .almost_empty(ae4)
    );

    axis_fifo_counted #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) u_d5 (
        .clk(clk), .rst(rst),
        .s_axis_tready(s5_rdy), .s_axis_tvalid(s5_vld), .s_axis_tdata(s5_dat),
        .m_axis_tready(m5_rdy), .m_axis_tvalid(m5_vld), .m_axis_tdata(m5_dat),
        .count(c5), .almost_full(af5), .almost_empty(ae5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic chk_state(input string tag, input int depth, input int afth, input int aeth,
                             input int mc, input logic rdy, input logic vld, input logic [2:0] cnt,
                             input logic afo, input logic aeo);
        chk({tag, " tready"}, 32'(rdy), 32'(mc != depth));
        chk({tag, " tvalid"}, 32'(vld), 32'(mc != 0));
        chk({tag, " count"}, 32'(cnt), 32'(mc));
        chk({tag, " almost_full"}, 32'(afo), 32'(mc >= afth));
        chk({tag, " almost_empty"}, 32'(aeo), 32'(mc <= aeth));
    endtask

    // One clock: check both instances mid-cycle, advance the models, then step past the edge.
    task automatic cycle(input string tag);
        logic in4, out4, in5, out5;
        @(negedge clk);
        chk_state({tag, "/d4"}, 4, 3, 1, mc4, s4_rdy, m4_vld, c4, af4, ae4);
        if (mc4 != 0) chk({tag, "/d4 tdata"}, 32'(m4_dat), 32'(q4[0]));
        chk_state({tag, "/d5"}, 5, 3, 1, mc5, s5_rdy, m5_vld, c5, af5, ae5);
        if (mc5 != 0) chk({tag, "/d5 tdata"}, 32'(m5_dat), 32'(q5[0]));
        if (int'(c5) > max_c5) max_c5 = int'(c5);

        in4  = s4_vld && (mc4 != 4);
        out4 = m4_rdy && (mc4 != 0);
        if (out4) void'(q4.pop_front());
        if (in4) q4.push_back(s4_dat);
        mc4 = mc4 + int'(in4) - int'(out4);

        in5  = s5_vld && (mc5 != 5);
        out5 = m5_rdy && (mc5 != 0);
        if (out5) begin
            void'(q5.pop_front());
            rcv5++;
        end
        if (in5) begin
            q5.push_back(s5_dat);
            sent5++;
        end
        acc5 = in5;
        mc5 = mc5 + int'(in5) - int'(out5);

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q4.delete();
        q5.delete();
        mc4 = 0;
        mc5 = 0;
    endtask

    initial begin
        rst = 1'b1;
        s4_vld = 1'b0; s4_dat = '0; m4_rdy = 1'b0;
        s5_vld = 1'b0; s5_dat = '0; m5_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("reset");

        // Single word through an empty FIFO
        m4_rdy = 1'b1; s4_vld = 1'b1; s4_dat = 8'hA5;
        cycle("single_push");
        s4_vld = 1'b0;
        chk("single tdata", 32'(m4_dat), 32'h0000_00A5);
        cycle("single_out");
        cycle("single_empty");

        // Fill to capacity with the consumer stalled
        m4_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s4_vld = 1'b1; s4_dat = 8'(i);
            cycle("fill");
        end
        chk("fill count", 32'(c4), 32'd4);
        chk("fill almost_full", 32'(af4), 32'd1);
        chk("fill tready", 32'(s4_rdy), 32'd0);

        // Read while full: no same-cycle write, slot reopens next cycle
        m4_rdy = 1'b1;
        cycle("full_rd");
        chk("full_rd count", 32'(c4), 32'd3);
        chk("full_rd reopen", 32'(s4_rdy), 32'd1);
        cycle("full_wr");
        s4_vld = 1'b0;
        repeat (6) cycle("drain");

        // Backpressure hold
        m4_rdy = 1'b0;
        s4_vld = 1'b1; s4_dat = 8'h3C;
        cycle("hold_push");
        s4_dat = 8'h7E;
        cycle("hold_push");
        s4_vld = 1'b0;
        repeat (10) cycle("hold");
        chk("hold tdata", 32'(m4_dat), 32'h0000_003C);
        m4_rdy = 1'b1;
        repeat (3) cycle("hold_drain");

        // Reset mid-stream with a word presented during reset
        m4_rdy = 1'b0;
        s4_vld = 1'b1;
        s4_dat = 8'hAA; cycle("pre_rst");
        s4_dat = 8'hBB; cycle("pre_rst");
        s4_dat = 8'hCC; cycle("pre_rst");
        chk("pre_rst count", 32'(c4), 32'd3);
        s4_dat = 8'hEE;
        do_reset();
        s4_vld = 1'b0;
        chk("post_rst count", 32'(c4), 32'd0);
        chk("post_rst tvalid", 32'(m4_vld), 32'd0);
        chk("post_rst almost_empty", 32'(ae4), 32'd1);
        cycle("post_rst");
        m4_rdy = 1'b1; s4_vld = 1'b1; s4_dat = 8'h11;
        cycle("post_rst_push");
        s4_vld = 1'b0;
        repeat (3) cycle("post_rst_drain");

        // Random streaming through the non-power-of-two instance
        sent5 = 0; rcv5 = 0; acc5 = 1'b0;
        for (int n = 0; n < 4000 && rcv5 < 100; n++) begin
            if (!(s5_vld && !acc5)) begin
                if (sent5 < 100 && $urandom_range(0, 1) == 1) begin
                    s5_vld = 1'b1;
                    s5_dat = 8'(sent5);
                end else begin
                    s5_vld = 1'b0;
                end
            end
            m5_rdy = ($urandom_range(0, 1) == 1);
            cycle("stream");
        end
        s5_vld = 1'b0;
        chk("stream received", 32'(rcv5), 32'd100);
        chk("stream max count", 32'(max_c5 <= 5), 32'd1);
        chk("stream final count", 32'(c5), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
